neuron_sequencer: RTL and testbench

Front-end sequencer that sits directly upstream of the neuron datapath and drives its `x`, `weight`, `acc_en` and `ready` inputs. It buffers `d` input samples arriving on a valid/ready stream and fetches the matching weights from a synchronous weight memory. It then issues exactly `d` aligned accumulate cycles and flags the activation stage once the accumulator holds the final sum.

---
 rtl/neuron_pkg.sv | 20 ++
 rtl/neuron_sequencer_sample_buffer.sv | 57 +++++
 rtl/neuron_sequencer.sv | 133 +++++++++++++
 tb/tb_neuron_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared types and default widths for the neuron front-end sequencer.
package neuron_pkg;

    localparam int DEF_N = 16;
    localparam int DEF_Q = 8;
    localparam int DEF_D = 4;

    typedef enum logic [1:0] {
        SEQ_LOAD,
        SEQ_RUN,
        SEQ_DRAIN,
        SEQ_DONE
    } seq_state_e;

    // 1.0 in a width-n format with q fraction bits; zero when it cannot be represented.
    function automatic logic [31:0] one_q(input int n, input int q);
        return (q < n && q < 32) ? (32'd1 << q) : 32'd0;
    endfunction

endpackage

// File: rtl/neuron_sequencer_sample_buffer.sv
// d-entry sample register file: sequential write pointer that wraps after
// entry d-1, and a combinational read port.
module sample_buffer
    import neuron_pkg::*;
#(
    parameter  int N  = DEF_N,
    parameter  int d  = DEF_D,
    localparam int AW = (d > 1) ? $clog2(d) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [N-1:0]  data_i,
    input  logic [AW-1:0] rd_idx_i,
    output logic [AW-1:0] wr_ptr_o,
    output logic [N-1:0]  rd_data_o
);

    logic [N-1:0]  mem_q [d];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (we_i) begin
            wr_ptr_d = (wr_ptr_q == AW'(d - 1)) ? '0 : wr_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Storage is not reset: every entry is rewritten before a new evaluation reads it.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < d; i++) begin
            if (we_i && (wr_ptr_q == AW'(i))) begin
                mem_q[i] <= data_i;
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < d; i++) begin
            if (rd_idx_i == AW'(i)) begin
                rd_data_o = mem_q[i];
            end
        end
    end

    assign wr_ptr_o = wr_ptr_q;

endmodule

// File: rtl/neuron_sequencer.sv
// Front-end sequencer: buffers d samples, then streams aligned (x, weight) pairs
// to the neuron datapath. Define NEURON_SEQ_BIAS_EN to append a bias accumulate slot.
module neuron_sequencer
    import neuron_pkg::*;
#(
    parameter  int N  = DEF_N,
    parameter  int Q  = DEF_Q,
    parameter  int d  = DEF_D,
    localparam int AW = (d > 1) ? $clog2(d) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [N-1:0]  in_data,
    output logic          in_ready,
    output logic [AW-1:0] w_addr,
    input  logic [N-1:0]  w_data,
`ifdef NEURON_SEQ_BIAS_EN
    input  logic [N-1:0]  bias,
`endif
    output logic [N-1:0]  x,
    output logic [N-1:0]  weight,
    output logic          acc_en,
    output logic          acc_clr,
    output logic          ready,
    output logic          done
);

    localparam int CW = $clog2(d + 2);
`ifdef NEURON_SEQ_BIAS_EN
    localparam int           RUN_LEN = d + 1;
    localparam logic [N-1:0] ONE     = N'(one_q(N, Q));
`else
    localparam int RUN_LEN = d;
`endif

    seq_state_e    state_q, state_d;
    logic [CW-1:0] rd_idx_q, rd_idx_d;
    logic [AW-1:0] wr_ptr, buf_idx;
    logic [N-1:0]  buf_data;
    logic [N-1:0]  x_q, x_d;
    logic          acc_en_q;
    logic          accept, last_accept;
`ifdef NEURON_SEQ_BIAS_EN
    logic          bias_slot_q, bias_slot_d;
`endif

    assign accept      = in_valid && (state_q == SEQ_LOAD);
    assign last_accept = accept && (wr_ptr == AW'(d - 1));
    // The bias slot keeps the last index so the buffer read stays in range.
    assign buf_idx     = (rd_idx_q >= CW'(d)) ? AW'(d - 1) : rd_idx_q[AW-1:0];

    sample_buffer #(
        .N (N),
        .d (d)
    ) u_buf (
        .clk_i     (clk),
        .rst_i     (rst),
        .we_i      (accept),
        .data_i    (in_data),
        .rd_idx_i  (buf_idx),
        .wr_ptr_o  (wr_ptr),
        .rd_data_o (buf_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEQ_LOAD;
            rd_idx_q    <= '0;
            acc_en_q    <= 1'b0;
`ifdef NEURON_SEQ_BIAS_EN
            bias_slot_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rd_idx_q    <= rd_idx_d;
            acc_en_q    <= (state_q == SEQ_RUN);
`ifdef NEURON_SEQ_BIAS_EN
            bias_slot_q <= bias_slot_d;
`endif
        end
    end

    // x_q is a pure data register; acc_en gating keeps the x output at zero when idle.
    always_ff @(posedge clk) begin
        x_q <= x_d;
    end

    always_comb begin
        state_d  = state_q;
        rd_idx_d = rd_idx_q;
        case (state_q)
            SEQ_LOAD: begin
                if (last_accept) begin
                    state_d  = SEQ_RUN;
                    rd_idx_d = '0;
                end
            end
            SEQ_RUN: begin
                if (rd_idx_q == CW'(RUN_LEN - 1)) begin
                    state_d  = SEQ_DRAIN;
                    rd_idx_d = '0;
                end else begin
                    rd_idx_d = rd_idx_q + CW'(1);
                end
            end
            SEQ_DRAIN: state_d = SEQ_DONE;
            SEQ_DONE:  state_d = SEQ_LOAD;
            default:   state_d = SEQ_LOAD;
        endcase
    end

    always_comb begin
        in_ready = (state_q == SEQ_LOAD);
        acc_clr  = (state_q == SEQ_RUN) && (rd_idx_q == '0);
        ready    = (state_q == SEQ_DONE);
        done     = (state_q == SEQ_DONE);
        w_addr   = (state_q == SEQ_RUN) ? buf_idx : '0;
        acc_en   = acc_en_q;
        x_d      = buf_data;
`ifdef NEURON_SEQ_BIAS_EN
        bias_slot_d = (state_q == SEQ_RUN) && (rd_idx_q == CW'(d));
        if (bias_slot_d) begin
            x_d = ONE;
        end
        weight = acc_en_q ? (bias_slot_q ? bias : w_data) : '0;
`else
        weight = acc_en_q ? w_data : '0;
`endif
        x = acc_en_q ? x_q : '0;
    end

endmodule

// File: tb/tb_neuron_sequencer.sv
// Self-checking bench for neuron_sequencer (d=4 main instance, d=1 side instance);
// follows NEURON_SEQ_BIAS_EN when defined.
module tb_neuron_sequencer;

    localparam int N = 16;
    localparam int D = 4;
`ifdef NEURON_SEQ_BIAS_EN
    localparam int NACC = D + 1;
`else
    localparam int NACC = D;
`endif
    localparam int           T_DONE = NACC + 2;
    localparam logic [N-1:0] ONE    = 16'd256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // main instance, d = 4
    logic         in_valid = 1'b0;
    logic [N-1:0] in_data  = '0;
    logic         in_ready;
    logic [1:0]   w_addr;
    logic [N-1:0] w_data   = '0;
    logic [N-1:0] x, weight;
    logic         acc_en, acc_clr, ready, done;
    logic [N-1:0] bias     = 16'd5;
    logic [N-1:0] wmem [D];

    // side instance, d = 1
    logic         in_valid1 = 1'b0;
    logic [N-1:0] in_data1  = '0;
    logic         in_ready1;
    logic [0:0]   w_addr1;
    logic [N-1:0] w_data1   = '0;
    logic [N-1:0] x1, weight1;
    logic         acc_en1, acc_clr1, ready1, done1;

    neuron_sequencer #(.N(N), .Q(8), .d(D)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .w_addr(w_addr), .w_data(w_data),
`ifdef NEURON_SEQ_BIAS_EN
        .bias(bias),
`endif
        .x(x), .weight(weight), .acc_en(acc_en), .acc_clr(acc_clr), .ready(ready), .done(done)
    );

    neuron_sequencer #(.N(N), .Q(8), .d(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
        .w_addr(w_addr1), .w_data(w_data1),
`ifdef NEURON_SEQ_BIAS_EN
        .bias(bias),
`endif
        .x(x1), .weight(weight1), .acc_en(acc_en1), .acc_clr(acc_clr1), .ready(ready1), .done(done1)
    );

    // synchronous weight memories with 1-cycle read latency
    always @(posedge clk) w_data  <= wmem[w_addr];
    always @(posedge clk) w_data1 <= (w_addr1 == 1'b0) ? 16'd3 : 16'd0;

    // Reference model: 'since' counts cycles after the cycle that accepted the d-th sample.
    int           since = 0;
    logic [N-1:0] smp [$];
    always @(posedge clk) begin
        if (rst) begin
            since = 0;
            smp.delete();
        end else if (since == 0) begin
            if (in_valid) begin
                smp.push_back(in_data);
                if (smp.size() == D) since = 1;
            end
        end else if (since == T_DONE) begin
            since = 0;
            smp.delete();
        end else begin
            since = since + 1;
        end
    end

    function automatic logic [38:0] exp_vec();
        int           k;
        logic         ee;
        logic [N-1:0] ex, ew;
        logic [1:0]   ea;
        k  = since - 2;
        ee = (since >= 2) && (since <= NACC + 1);
        ex = '0;
        ew = '0;
        if (ee) begin
            ex = (k < D) ? smp[k] : ONE;
            ew = (k < D) ? wmem[k] : bias;
        end
        ea = 2'd0;
        if (since >= 1 && since <= NACC) ea = 2'((since - 1 < D) ? since - 1 : D - 1);
        return {since == 0, ea, ex, ew, ee, since == 1, since == T_DONE, since == T_DONE};
    endfunction

    function automatic logic [38:0] dut_vec();
        return {in_ready, w_addr, x, weight, acc_en, acc_clr, ready, done};
    endfunction

    task automatic test_reset();
        logic [38:0] o;
        in_valid = 1'b0;
        rst      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) rst = 1'b0;
            @(negedge clk);
            o = dut_vec();
            vectors++;
            if (o !== {1'b1, 38'd0}) begin
                miscompares++;
                $display("FAIL reset cyc%0d: got %h, expected %h", i, o, {1'b1, 38'd0});
            end
            vectors++;
            if ({in_ready1, w_addr1, acc_en1, acc_clr1, ready1, done1, x1, weight1} !== {1'b1, 5'd0, 32'd0}) begin
                miscompares++;
                $display("FAIL reset_d1 cyc%0d: got %h, expected %h", i,
                         {in_ready1, w_addr1, acc_en1, acc_clr1, ready1, done1, x1, weight1}, {1'b1, 5'd0, 32'd0});
            end
        end
    endtask

    task automatic test_basic();
        logic [38:0] o, e;
        int          sum;
        int          expsum;
        wmem[0] = 16'd10; wmem[1] = 16'd20; wmem[2] = 16'd30; wmem[3] = 16'd40;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sum = 0;
        for (int i = 0; i < 4 + T_DONE + 2; i++) begin
            in_valid = (i < 4);
            in_data  = N'(i + 1);
            @(negedge clk);
            o = dut_vec();
            e = exp_vec();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL basic cyc%0d: got %h, expected %h", i, o, e);
            end
            if (acc_clr) sum = 0;
            if (acc_en) sum += int'(x) * int'(weight);
        end
`ifdef NEURON_SEQ_BIAS_EN
        expsum = 300 + 256 * 5;
`else
        expsum = 300;
`endif
        vectors++;
        if (sum !== expsum) begin
            miscompares++;
            $display("FAIL basic_sum: got %0d, expected %0d", sum, expsum);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_gaps();
        logic [38:0] o, e;
        logic [5:0]  pat;
        int          ncyc;
        pat  = 6'b101101;
        ncyc = 6 + (T_DONE + 1) + 3 + (T_DONE + 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            if (i < 6) begin
                in_valid = pat[5 - i];
                in_data  = N'($urandom);
            end else if (i < 6 + T_DONE + 1) begin
                in_valid = 1'b1;
                in_data  = 16'h0099;
            end else if (i < 6 + T_DONE + 4) begin
                in_valid = 1'b1;
                in_data  = N'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            o = dut_vec();
            e = exp_vec();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL gaps cyc%0d: got %h, expected %h", i, o, e);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [38:0] o, e;
        bit          hit;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 4 + 10 && !hit; i++) begin
            in_valid = (i < 4);
            in_data  = N'($urandom);
            @(negedge clk);
            o = dut_vec();
            e = exp_vec();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL rstmid_pre cyc%0d: got %h, expected %h", i, o, e);
            end
            if (since == 3) hit = 1'b1;
        end
        in_valid = 1'b0;
        vectors++;
        if (!hit || acc_en !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_reach: got acc_en=%b reached=%b, expected 1 1", acc_en, hit);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (acc_en !== 1'b0 || in_ready !== 1'b1 || ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_after: got acc_en=%b in_ready=%b ready=%b, expected 0 1 0", acc_en, in_ready, ready);
        end
        for (int i = 0; i < 3 + 5 + 1 + T_DONE + 2; i++) begin
            in_valid = (i < 3) || (i == 8);
            in_data  = N'($urandom);
            @(negedge clk);
            o = dut_vec();
            e = exp_vec();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL rstmid_post cyc%0d: got %h, expected %h", i, o, e);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_single();
        in_valid1 = 1'b1;
        in_data1  = 16'd7;
        @(negedge clk);
        in_valid1 = 1'b0;
        vectors++;
        if ({acc_clr1, acc_en1, in_ready1, w_addr1, done1} !== 5'b10000) begin
            miscompares++;
            $display("FAIL single_t1: got clr,en,rdy,addr,done=%b, expected 10000",
                     {acc_clr1, acc_en1, in_ready1, w_addr1, done1});
        end
        @(negedge clk);
        vectors++;
        if ({acc_en1, acc_clr1, done1, in_ready1, x1, weight1} !== {4'b1000, 16'd7, 16'd3}) begin
            miscompares++;
            $display("FAIL single_t2: got en=%b clr=%b done=%b x=%0d w=%0d, expected en=1 x=7 w=3",
                     acc_en1, acc_clr1, done1, x1, weight1);
        end
`ifdef NEURON_SEQ_BIAS_EN
        @(negedge clk);
        vectors++;
        if ({acc_en1, done1, x1, weight1} !== {2'b10, ONE, bias}) begin
            miscompares++;
            $display("FAIL single_bias: got en=%b done=%b x=%0d w=%0d, expected en=1 x=256 w=%0d",
                     acc_en1, done1, x1, weight1, bias);
        end
`endif
        @(negedge clk);
        vectors++;
        if ({done1, ready1, acc_en1, in_ready1, x1, weight1} !== {4'b1100, 32'd0}) begin
            miscompares++;
            $display("FAIL single_done: got done=%b ready=%b en=%b in_ready=%b x=%0d w=%0d, expected 1 1 0 0 0 0",
                     done1, ready1, acc_en1, in_ready1, x1, weight1);
        end
        @(negedge clk);
        vectors++;
        if ({in_ready1, done1, ready1} !== 3'b100) begin
            miscompares++;
            $display("FAIL single_reload: got in_ready=%b done=%b ready=%b, expected 1 0 0", in_ready1, done1, ready1);
        end
    endtask

    task automatic test_random();
        logic [38:0] o, e;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < D; i++) wmem[i] = N'($urandom);
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = N'($urandom);
            rst      = ($urandom_range(0, 59) == 0);
            @(negedge clk);
            o = dut_vec();
            e = exp_vec();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL random cyc%0d: got %h, expected %h", i, o, e);
            end
        end
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < D; i++) wmem[i] = '0;
        test_reset();
        test_basic();
        test_gaps();
        test_reset_mid();
        test_single();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within 200000 time units");
        $fatal(1);
    end

endmodule
